// File: rtl/sobel_gcd_pkg.sv
// Shared types and constants for the Sobel/GCD byte-stream interfaces.
// The SPI responder supports mode 0 only; SPI_MODE documents that.
package sobel_gcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } spi_state_t;

    localparam logic [7:0] SPI_IDLE_BYTE = 8'h00;
    localparam int         SPI_MODE      = 0;  // CPOL=0, CPHA=0, MSB first

endpackage

// File: rtl/sobel_tx_fifo.sv
// Synchronous FIFO holding bytes from the core until the SPI host reads them.
// Push is refused when full and pop is ignored when empty.
module sobel_tx_fifo
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
)
(
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  full_o,
    output logic                  empty_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty_o = (count_q == '0);
    assign data_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count_q alone decides what is readable.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/sobel_spi_slave.sv
// SPI mode-0 responder: oversampled pins feed an IDLE/LOAD/SHIFT FSM that
// emits received bytes as pulses and shifts out bytes drawn from the TX FIFO.
module sobel_spi_slave
    import sobel_gcd_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
)
(
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  spi_sclk_i,
    input  logic                  spi_cs_ni,
    input  logic                  spi_mosi_i,
    output logic                  spi_miso_o,
    output logic                  spi_miso_oe_o,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  rx_valid_o,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    input  logic                  tx_valid_i,
    output logic                  tx_ready_o,
    output logic                  tx_underrun_o,
    output logic                  busy_o
);
    localparam int BIT_W = $clog2(DATA_WIDTH);

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   cs_prev_q,   cs_prev_d;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

    spi_state_t             state_q, state_d;
    logic [DATA_WIDTH-1:0]  tx_shreg_q, tx_shreg_d;
    logic [DATA_WIDTH-1:0]  rx_shreg_q, rx_shreg_d;
    logic [DATA_WIDTH-1:0]  rx_data_q,  rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic [BIT_W-1:0]       bit_cnt_q,  bit_cnt_d;
    logic                   byte_done_q, byte_done_d;
    logic                   last_bit;

    logic                   fifo_pop, fifo_full, fifo_empty;
    logic [DATA_WIDTH-1:0]  fifo_dout;

    // Pin synchronisers and one-cycle-delayed copies for edge detection
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk_i};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0],   spi_cs_ni};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
        sclk_prev_d = sclk_s;
        cs_prev_d   = cs_s;
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s  && !sclk_prev_q;
    assign sclk_fall = !sclk_s && sclk_prev_q;
    assign cs_rise   = cs_s    && !cs_prev_q;
    assign cs_fall   = !cs_s   && cs_prev_q;
    assign last_bit  = (bit_cnt_q == BIT_W'(DATA_WIDTH-1));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_prev_q <= sclk_prev_d;
            cs_prev_q   <= cs_prev_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // CS release wins over everything, so a partial byte is simply abandoned.
    always_comb begin
        state_d = state_q;
        if (cs_rise) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (cs_fall) state_d = LOAD;
                LOAD:    state_d = SHIFT;
                SHIFT:   if (sclk_fall && byte_done_q) state_d = LOAD;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        spi_miso_o    = 1'b0;
        spi_miso_oe_o = 1'b0;
        fifo_pop      = 1'b0;
        tx_underrun_o = 1'b0;
        case (state_q)
            LOAD: begin
                spi_miso_oe_o = 1'b1;
                if (!cs_rise) begin
                    fifo_pop      = !fifo_empty;
                    tx_underrun_o = fifo_empty;
                end
            end
            SHIFT: begin
                spi_miso_oe_o = 1'b1;
                spi_miso_o    = tx_shreg_q[DATA_WIDTH-1];
            end
            default: ;
        endcase
    end

    // Shift datapath; byte_done marks that the next SCLK fall starts a new byte
    always_comb begin
        tx_shreg_d  = tx_shreg_q;
        rx_shreg_d  = rx_shreg_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        bit_cnt_d   = bit_cnt_q;
        byte_done_d = byte_done_q;
        if (state_q == IDLE || cs_rise) begin
            bit_cnt_d   = '0;
            byte_done_d = 1'b0;
        end else if (state_q == LOAD) begin
            tx_shreg_d  = fifo_empty ? DATA_WIDTH'(SPI_IDLE_BYTE) : fifo_dout;
            byte_done_d = 1'b0;
        end else if (state_q == SHIFT) begin
            if (sclk_rise) begin
                rx_shreg_d = {rx_shreg_q[DATA_WIDTH-2:0], mosi_s};
                bit_cnt_d  = last_bit ? '0 : bit_cnt_q + BIT_W'(1);
                if (last_bit) begin
                    rx_data_d   = rx_shreg_d;
                    rx_valid_d  = 1'b1;
                    byte_done_d = 1'b1;
                end
            end
            if (sclk_fall && !byte_done_q) tx_shreg_d = tx_shreg_q << 1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            tx_shreg_q  <= '0;
            rx_shreg_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            bit_cnt_q   <= '0;
            byte_done_q <= 1'b0;
        end else begin
            tx_shreg_q  <= tx_shreg_d;
            rx_shreg_q  <= rx_shreg_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_done_q <= byte_done_d;
        end
    end

    sobel_tx_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (tx_valid_i && tx_ready_o),
        .data_i  (tx_data_i),
        .pop_i   (fifo_pop),
        .data_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign tx_ready_o = !fifo_full && !reset_i;
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
    assign busy_o     = !cs_s;

endmodule

// File: tb/tb_sobel_spi_slave.sv
// Bench for sobel_spi_slave: host-side SPI driver plus a queue model of the
// TX FIFO; every byte slot the host starts consumes one FIFO entry or 0x00.
module tb_sobel_spi_slave;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset_i;
    logic       spi_sclk_i, spi_cs_ni, spi_mosi_i;
    logic       spi_miso_o, spi_miso_oe_o;
    logic [7:0] rx_data_o, tx_data_i;
    logic       rx_valid_o, tx_valid_i, tx_ready_o, tx_underrun_o, busy_o;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] model_q[$];
    logic [7:0] rx_q[$];
    int         und_seen = 0;
    logic [7:0] mosi_buf[8];
    logic [7:0] miso_got[8];

    sobel_spi_slave #(.DATA_WIDTH(8), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .spi_sclk_i    (spi_sclk_i),
        .spi_cs_ni     (spi_cs_ni),
        .spi_mosi_i    (spi_mosi_i),
        .spi_miso_o    (spi_miso_o),
        .spi_miso_oe_o (spi_miso_oe_o),
        .rx_data_o     (rx_data_o),
        .rx_valid_o    (rx_valid_o),
        .tx_data_i     (tx_data_i),
        .tx_valid_i    (tx_valid_i),
        .tx_ready_o    (tx_ready_o),
        .tx_underrun_o (tx_underrun_o),
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid_o === 1'b1)    rx_q.push_back(rx_data_o);
        if (tx_underrun_o === 1'b1) und_seen++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v)
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic push(input logic [7:0] d);
        tx_data_i  = d;
        tx_valid_i = 1'b1;
        check("tx_ready_on_push", tx_ready_o, model_q.size() < DEPTH);
        if (model_q.size() < DEPTH) model_q.push_back(d);
        wait_clk(1);
        tx_valid_i = 1'b0;
    endtask

    // nbytes full bytes, then optionally pbits of an abandoned byte.
    // A full transfer ends by raising CS together with the final SCLK fall.
    task automatic xfer(input int nbytes, input int pbits, input int hp);
        int         loads, exp_und, sz_first, rx_base, und_base, nb, n_rx;
        logic [7:0] exp_miso[8];
        loads    = nbytes + ((pbits > 0) ? 1 : 0);
        exp_und  = 0;
        sz_first = model_q.size();
        for (int k = 0; k < loads; k++) begin
            if (model_q.size() > 0) exp_miso[k] = model_q.pop_front();
            else begin
                exp_miso[k] = 8'h00;
                exp_und++;
            end
            if (k == 0) sz_first = model_q.size();
        end
        rx_base   = rx_q.size();
        und_base  = und_seen;
        spi_cs_ni = 1'b0;
        for (int b = 0; b < loads; b++) begin
            nb = (b < nbytes) ? 8 : pbits;
            for (int i = 0; i < nb; i++) begin
                spi_mosi_i = mosi_buf[b][7-i];
                wait_clk(hp);
                if (b < nbytes) miso_got[b][7-i] = spi_miso_o;
                if (b == 0 && i == 0) begin
                    check("busy_in_xfer", busy_o, 1);
                    check("ready_after_pop", tx_ready_o, sz_first < DEPTH);
                end
                spi_sclk_i = 1'b1;
                wait_clk(hp);
                if (b == nbytes - 1 && i == 7 && pbits == 0) spi_cs_ni = 1'b1;
                spi_sclk_i = 1'b0;
            end
        end
        if (pbits > 0) begin
            wait_clk(hp);
            spi_cs_ni = 1'b1;
        end
        wait_clk(12);
        n_rx = rx_q.size() - rx_base;
        check("rx_count", n_rx, nbytes);
        for (int b = 0; b < nbytes && b < n_rx; b++) begin
            check("rx_data", rx_q[rx_base + b], mosi_buf[b]);
            check("miso_byte", miso_got[b], exp_miso[b]);
        end
        check("underrun_count", und_seen - und_base, exp_und);
        check("busy_after", busy_o, 0);
        check("oe_after", spi_miso_oe_o, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_miso"},     spi_miso_o, 0);
        check({tag, "_oe"},       spi_miso_oe_o, 0);
        check({tag, "_rx_data"},  rx_data_o, 0);
        check({tag, "_rx_valid"}, rx_valid_o, 0);
        check({tag, "_ready"},    tx_ready_o, 0);
        check({tag, "_underrun"}, tx_underrun_o, 0);
        check({tag, "_busy"},     busy_o, 0);
    endtask

    initial begin
        int rx_before;
        reset_i    = 1'b1;
        spi_sclk_i = 1'b0;
        spi_cs_ni  = 1'b1;
        spi_mosi_i = 1'b0;
        tx_data_i  = 8'h00;
        tx_valid_i = 1'b0;
        wait_clk(4);
        check_all_zero("reset");
        reset_i = 1'b0;
        wait_clk(1);
        check("ready_after_reset", tx_ready_o, 1);

        // Single byte with an empty FIFO
        mosi_buf[0] = 8'hA5;
        xfer(1, 0, 8);

        // Two queued bytes, two-byte transfer
        push(8'h3C);
        push(8'hF0);
        mosi_buf[0] = 8'h12;
        mosi_buf[1] = 8'h34;
        xfer(2, 0, 8);

        // Overfill: the fifth push is refused
        for (int k = 0; k < 5; k++) push(8'h50 + 8'(k));
        for (int b = 0; b < 4; b++) mosi_buf[b] = 8'($urandom);
        xfer(4, 0, 8);

        // Abandoned byte after 5 bits; its TX byte is not re-sent
        push(8'h5A);
        push(8'h6B);
        mosi_buf[0] = 8'hFF;
        xfer(0, 5, 8);
        check("idle_state_oe", spi_miso_oe_o, 0);
        mosi_buf[0] = 8'h81;
        xfer(1, 0, 8);

        // Reset mid-byte with two FIFO entries
        push(8'hC3);
        push(8'h96);
        rx_before = rx_q.size();
        spi_cs_ni = 1'b0;
        for (int i = 0; i < 3; i++) begin
            spi_mosi_i = 1'b1;
            wait_clk(8);
            spi_sclk_i = 1'b1;
            wait_clk(8);
            spi_sclk_i = 1'b0;
        end
        wait_clk(3);
        reset_i   = 1'b1;
        spi_cs_ni = 1'b1;
        wait_clk(1);
        check_all_zero("midreset");
        wait_clk(1);
        reset_i = 1'b0;
        model_q.delete();
        wait_clk(1);
        check("ready_after_midreset", tx_ready_o, 1);
        check("no_rx_on_reset", rx_q.size() - rx_before, 0);
        mosi_buf[0] = 8'h7E;
        xfer(1, 0, 8);

        // Randomised traffic against the queue model
        for (int it = 0; it < 8; it++) begin
            int npush, nb, hp;
            npush = $urandom_range(0, 5);
            for (int k = 0; k < npush; k++) push(8'($urandom));
            nb = $urandom_range(1, 3);
            for (int b = 0; b < nb; b++) mosi_buf[b] = 8'($urandom);
            hp = $urandom_range(5, 9);
            xfer(nb, 0, hp);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
